instruction_decode: RTL and testbench
=====================================

INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no parameters.
REQ-002 clk  input  1  sole clock; all outputs register on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 instruction  input  32  RV32 instruction word to decode.
REQ-005 opcode  output  5  major opcode, instruction[6:2].
REQ-006 alu_control  output  5  ALU operation code, encoding per REQ-013.
REQ-007 Rd  output  4  destination register, instruction[10:7] (RV32E, 16 registers).
REQ-008 Rs  output  4  source register 1, instruction[18:15].
REQ-009 Rt  output  4  source register 2, instruction[23:20].
REQ-010 imm  output  15  imm_ext[14:0].
REQ-011 imm_ext  output  32  sign-extended, format-selected immediate.

Function
REQ-012 All outputs SHALL be registered: values decoded from `instruction` appear one clk edge after it is presented, updating every cycle with no enable.
REQ-013 alu_control encoding: ADD 00000, SUB 00001, SLL 00010, SLT 00011, SLTU 00100, XOR 00101, SRL 00110, SRA 00111, OR 01000, AND 01001, MUL 01010, MULH 01011, MULHSU 01100, MULHU 01101, DIV 01110, DIVU 01111, REM 10000, REMU 10001, PASSB 10010, ILLEGAL 11111.
REQ-014 OP (01100): funct7=0000000 selects from funct3 (ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND); funct7=0100000 with funct3 000 gives SUB and with 101 gives SRA; funct7=0000001 selects the M codes by funct3; any other funct7/funct3 combination gives ILLEGAL.
REQ-015 OP-IMM (00100): decoded as REQ-014 using funct3; funct3=101 with instruction[30]=1 gives SRA; the SUB form does not exist here.
REQ-016 LOAD (00000), STORE (01000), JALR (11001), JAL (11011) and AUIPC (00101) SHALL give ADD; LUI (01101) SHALL give PASSB.
REQ-017 BRANCH (11000): BEQ/BNE give SUB, BLT/BGE give SLT, BLTU/BGEU give SLTU; funct3 010/011 give ILLEGAL.
REQ-018 Any other opcode SHALL give ILLEGAL.
REQ-019 imm_ext format: I-type for LOAD/OP-IMM/JALR, S for STORE, B for BRANCH, U for LUI/AUIPC, J for JAL, all sign-extended from instruction[31]; it SHALL be zero for OP and illegal opcodes.
REQ-020 Rd/Rs/Rt SHALL always carry the raw bit fields regardless of format; bit 4 of each RV register field (bits 11, 19, 24) SHALL be ignored.

Reset
REQ-021 While rst_n=0, all outputs SHALL be 0, asynchronously.
REQ-022 The first capture SHALL occur on the first rising clk edge after rst_n deasserts.

Configuration
REQ-023 With macro RV_M_EXT_EN defined, funct7=0000001 in OP SHALL decode to the M codes; without it, that funct7 SHALL give ILLEGAL.

Structure
REQ-024 Package instr_decode_pkg SHALL hold the opcode constants, the alu_control code constants and the immediate-format enum.
REQ-025 Sub-module imm_gen SHALL be purely combinational and produce imm_ext from the instruction and format.

Verification
REQ-026 0x00940333 (add) -> after 1 edge: opcode 01100, alu 00000, Rd 0110, Rs 1000, Rt 1001, imm_ext 0.
REQ-027 0x413903B3 (sub) -> opcode 01100, alu 00001, Rd 0111, Rs 0010, Rt 0011.
REQ-028 0x035A02B3 (mul) -> alu 01010 with RV_M_EXT_EN, 11111 without; Rd 0101, Rs 0100, Rt 0101.
REQ-029 0xFFF00093 (addi -1) -> opcode 00100, alu 00000, imm_ext 0xFFFFFFFF, imm 0x7FFF; 0xFE000EE3 (beq, offset -4) -> alu 00001, imm_ext 0xFFFFFFFC.
REQ-030 Assert rst_n=0 mid-stream with non-zero outputs -> all outputs 0 immediately, without waiting for a clk edge; opcode 1111111 -> alu 11111, imm_ext 0.

Source files
------------

// File: rtl/instruction_decode_pkg.sv
// Shared constants and types for the RV32 instruction decoder.
// Holds the major-opcode constants (instruction[6:2]), the alu_control
// code points and the immediate-format enum used by imm_gen.
package instr_decode_pkg;

  // Major opcodes, instruction[6:2]
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  // alu_control code points
  localparam logic [4:0] ALU_ADD     = 5'b00000;
  localparam logic [4:0] ALU_SUB     = 5'b00001;
  localparam logic [4:0] ALU_SLL     = 5'b00010;
  localparam logic [4:0] ALU_SLT     = 5'b00011;
  localparam logic [4:0] ALU_SLTU    = 5'b00100;
  localparam logic [4:0] ALU_XOR     = 5'b00101;
  localparam logic [4:0] ALU_SRL     = 5'b00110;
  localparam logic [4:0] ALU_SRA     = 5'b00111;
  localparam logic [4:0] ALU_OR      = 5'b01000;
  localparam logic [4:0] ALU_AND     = 5'b01001;
  localparam logic [4:0] ALU_MUL     = 5'b01010;
  localparam logic [4:0] ALU_PASSB   = 5'b10010;
  localparam logic [4:0] ALU_ILLEGAL = 5'b11111;

  // Immediate formats; FMT_NONE yields a zero immediate
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

endpackage

// File: rtl/instruction_decode_if.sv
// Bus bundle between an instruction source and the decoder.
//   instruction : 32-bit RV32 word presented to the decoder
//   opcode      : instruction[6:2]
//   alu_control : ALU operation code
//   Rd, Rs, Rt  : raw 4-bit register fields (RV32E)
//   imm         : imm_ext[14:0]
//   imm_ext     : sign-extended, format-selected immediate
// master drives instruction and reads the decode; slave is the decoder.
interface instruction_decode_if;
  logic [31:0] instruction;
  logic [4:0]  opcode;
  logic [4:0]  alu_control;
  logic [3:0]  Rd;
  logic [3:0]  Rs;
  logic [3:0]  Rt;
  logic [14:0] imm;
  logic [31:0] imm_ext;

  modport master (
    output instruction,
    input  opcode, alu_control, Rd, Rs, Rt, imm, imm_ext
  );

  modport slave (
    input  instruction,
    output opcode, alu_control, Rd, Rs, Rt, imm, imm_ext
  );
endinterface

// File: rtl/instruction_decode_imm_gen.sv
// imm_gen: purely combinational immediate builder.
//   instruction : instruction[31:7] (the low bits never carry immediate data)
//   fmt         : immediate format selected by the opcode
//   imm_ext     : sign-extended immediate, zero for FMT_NONE
module imm_gen
  import instr_decode_pkg::*;
(
  input  logic [31:7] instruction,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm_ext
);

  always_comb begin
    imm_ext = '0;
    unique case (fmt)
      FMT_I: imm_ext = {{20{instruction[31]}}, instruction[31:20]};
      FMT_S: imm_ext = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      FMT_B: imm_ext = {{19{instruction[31]}}, instruction[31], instruction[7],
                        instruction[30:25], instruction[11:8], 1'b0};
      FMT_U: imm_ext = {instruction[31:12], 12'b0};
      FMT_J: imm_ext = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                        instruction[20], instruction[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: registered RV32 instruction decoder.
//   clk   : sole clock, all outputs register on its rising edge
//   rst_n : asynchronous active-low reset, clears every output
//   bus   : instruction_decode_if.slave (instruction in, decode fields out)
// Optional feature: define RV_M_EXT_EN to decode OP funct7=0000001 as the
// M-extension codes; otherwise that encoding is ILLEGAL.
module instruction_decode
  import instr_decode_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  instruction_decode_if.slave  bus
);

  function automatic logic [4:0] decode_alu(input logic [31:0] ins);
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] base;
    logic [4:0] res;
    f3  = ins[14:12];
    f7  = ins[31:25];
    res = ALU_ILLEGAL;
    case (f3)
      3'b000:  base = ALU_ADD;
      3'b001:  base = ALU_SLL;
      3'b010:  base = ALU_SLT;
      3'b011:  base = ALU_SLTU;
      3'b100:  base = ALU_XOR;
      3'b101:  base = ALU_SRL;
      3'b110:  base = ALU_OR;
      default: base = ALU_AND;
    endcase
    case (ins[6:2])
      OPC_OP: begin
        if (f7 == 7'b0000000)
          res = base;
        else if (f7 == 7'b0100000 && f3 == 3'b000)
          res = ALU_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101)
          res = ALU_SRA;
`ifdef RV_M_EXT_EN
        // M codes are contiguous from MUL in funct3 order
        else if (f7 == 7'b0000001)
          res = ALU_MUL + 5'(f3);
`endif
        else
          res = ALU_ILLEGAL;
      end
      // Only bit 30 distinguishes SRAI from SRLI; there is no SUBI
      OPC_OP_IMM: res = (f3 == 3'b101 && ins[30]) ? ALU_SRA : base;
      OPC_LOAD, OPC_STORE, OPC_JALR, OPC_JAL, OPC_AUIPC: res = ALU_ADD;
      OPC_LUI: res = ALU_PASSB;
      OPC_BRANCH: begin
        case (f3)
          3'b000, 3'b001: res = ALU_SUB;
          3'b100, 3'b101: res = ALU_SLT;
          3'b110, 3'b111: res = ALU_SLTU;
          default:        res = ALU_ILLEGAL;
        endcase
      end
      default: res = ALU_ILLEGAL;
    endcase
    return res;
  endfunction

  function automatic imm_fmt_e decode_fmt(input logic [4:0] op);
    imm_fmt_e f;
    case (op)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: f = FMT_I;
      OPC_STORE:                      f = FMT_S;
      OPC_BRANCH:                     f = FMT_B;
      OPC_LUI, OPC_AUIPC:             f = FMT_U;
      OPC_JAL:                        f = FMT_J;
      default:                        f = FMT_NONE;
    endcase
    return f;
  endfunction

  logic [4:0]  opcode_p0;
  logic [4:0]  alu_p0;
  imm_fmt_e    fmt_p0;
  logic [31:0] imm_ext_p0;
  // The length field instruction[1:0] plays no part in this decode
  logic        unused_len;

  assign unused_len = &{1'b0, bus.instruction[1:0]};

  // Stage p0: combinational decode of the presented word
  assign opcode_p0 = bus.instruction[6:2];
  assign alu_p0    = decode_alu(bus.instruction);
  assign fmt_p0    = decode_fmt(opcode_p0);

  imm_gen u_imm_gen (
    .instruction (bus.instruction[31:7]),
    .fmt         (fmt_p0),
    .imm_ext     (imm_ext_p0)
  );

  // Stage p0 -> p1: output registers; register fields are raw, bit 4 dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.opcode      <= '0;
      bus.alu_control <= '0;
      bus.Rd          <= '0;
      bus.Rs          <= '0;
      bus.Rt          <= '0;
      bus.imm         <= '0;
      bus.imm_ext     <= '0;
    end else begin
      bus.opcode      <= opcode_p0;
      bus.alu_control <= alu_p0;
      bus.Rd          <= bus.instruction[10:7];
      bus.Rs          <= bus.instruction[18:15];
      bus.Rt          <= bus.instruction[23:20];
      bus.imm         <= imm_ext_p0[14:0];
      bus.imm_ext     <= imm_ext_p0;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Testbench for instruction_decode: random and directed instruction words
// against a behavioural decode model; outputs compared every falling edge.
// Honours RV_M_EXT_EN the same way the design does.
module tb_instruction_decode;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   failed = 0;

  logic        cap_valid = 1'b0;
  logic [31:0] cap_instr = '0;

  instruction_decode_if bus ();

  instruction_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] BASE_TBL [8] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
  localparam logic [4:0] OPS [9] = '{5'h0C, 5'h04, 5'h00, 5'h08, 5'h19,
                                     5'h1B, 5'h05, 5'h0D, 5'h18};

  function automatic logic [4:0] model_alu(input logic [31:0] ins);
    int op, f3, f7;
    op = int'(ins[6:2]);
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    if (op == 12) begin
      if (f7 == 0) return BASE_TBL[f3];
      if (f7 == 32 && f3 == 0) return 5'd1;
      if (f7 == 32 && f3 == 5) return 5'd7;
`ifdef RV_M_EXT_EN
      if (f7 == 1) return 5'(10 + f3);
`endif
      return 5'd31;
    end
    if (op == 4) return (f3 == 5 && ins[30]) ? 5'd7 : BASE_TBL[f3];
    if (op == 0 || op == 8 || op == 25 || op == 27 || op == 5) return 5'd0;
    if (op == 13) return 5'd18;
    if (op == 24) begin
      if (f3 <= 1) return 5'd1;
      if (f3 == 4 || f3 == 5) return 5'd3;
      if (f3 >= 6) return 5'd4;
      return 5'd31;
    end
    return 5'd31;
  endfunction

  // Immediates assembled arithmetically from the signed word
  function automatic logic [31:0] model_imm(input logic [31:0] ins);
    logic signed [31:0] s;
    int op;
    s  = ins;
    op = int'(ins[6:2]);
    if (op == 0 || op == 4 || op == 25) return 32'(s >>> 20);
    if (op == 8) return 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
    if (op == 24) return 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11) |
                         (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    if (op == 13 || op == 5) return ins & 32'hFFFF_F000;
    if (op == 27) return 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) |
                         (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    return 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Which word (if any) the outputs should currently reflect
  always @(posedge clk) begin
    cap_valid <= rst_n;
    cap_instr <= bus.instruction;
  end

  always @(negedge clk) begin
    logic [31:0] w;
    logic        live;
    w    = cap_instr;
    live = rst_n && cap_valid;
    check("opcode",  32'(bus.opcode),      live ? 32'(w[6:2])       : 32'd0);
    check("alu",     32'(bus.alu_control), live ? 32'(model_alu(w)) : 32'd0);
    check("rd",      32'(bus.Rd),          live ? 32'(w[10:7])      : 32'd0);
    check("rs",      32'(bus.Rs),          live ? 32'(w[18:15])     : 32'd0);
    check("rt",      32'(bus.Rt),          live ? 32'(w[23:20])     : 32'd0);
    check("imm_ext", bus.imm_ext,          live ? model_imm(w)      : 32'd0);
    check("imm",     32'(bus.imm),         live ? (model_imm(w) & 32'h7FFF) : 32'd0);
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w   = $urandom();
    sel = $urandom_range(0, 9);
    if (sel < 9) w[6:2] = OPS[sel];
    w[1:0] = 2'b11;
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  // Present a word, then land 1 time unit after the edge that captures it
  task automatic present(input logic [31:0] w);
    @(posedge clk);
    #2 bus.instruction = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.instruction = 32'h0094_0333;
    @(posedge clk);
    #1;
    check("reset_opcode",  32'(bus.opcode),      32'd0);
    check("reset_alu",     32'(bus.alu_control), 32'd0);
    check("reset_imm_ext", bus.imm_ext,          32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("add_opcode", 32'(bus.opcode),      32'b01100);
    check("add_alu",    32'(bus.alu_control), 32'b00000);
    check("add_rd",     32'(bus.Rd),          32'b0110);
    check("add_rs",     32'(bus.Rs),          32'b1000);
    check("add_rt",     32'(bus.Rt),          32'b1001);
    check("add_imm",    bus.imm_ext,          32'd0);

    present(32'h4139_03B3);
    check("sub_opcode", 32'(bus.opcode),      32'b01100);
    check("sub_alu",    32'(bus.alu_control), 32'b00001);
    check("sub_rd",     32'(bus.Rd),          32'b0111);
    check("sub_rs",     32'(bus.Rs),          32'b0010);
    check("sub_rt",     32'(bus.Rt),          32'b0011);

    present(32'h035A_02B3);
`ifdef RV_M_EXT_EN
    check("mul_alu", 32'(bus.alu_control), 32'b01010);
`else
    check("mul_alu", 32'(bus.alu_control), 32'b11111);
`endif
    check("mul_rd", 32'(bus.Rd), 32'b0101);
    check("mul_rs", 32'(bus.Rs), 32'b0100);
    check("mul_rt", 32'(bus.Rt), 32'b0101);

    present(32'hFFF0_0093);
    check("addi_opcode", 32'(bus.opcode),      32'b00100);
    check("addi_alu",    32'(bus.alu_control), 32'b00000);
    check("addi_immext", bus.imm_ext,          32'hFFFF_FFFF);
    check("addi_imm",    32'(bus.imm),         32'h7FFF);

    present(32'h1234_5037);
    check("lui_alu",    32'(bus.alu_control), 32'b10010);
    check("lui_immext", bus.imm_ext,          32'h1234_5000);

    present(32'hFE00_0EE3);
    check("beq_alu",    32'(bus.alu_control), 32'b00001);
    check("beq_immext", bus.imm_ext,          32'hFFFF_FFFC);

    // Asynchronous clear while outputs are non-zero
    #2 rst_n = 1'b0;
    #1;
    check("async_alu",     32'(bus.alu_control), 32'd0);
    check("async_imm_ext", bus.imm_ext,          32'd0);
    check("async_opcode",  32'(bus.opcode),      32'd0);
    check("async_rs",      32'(bus.Rs),          32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    present(32'hFFFF_FFFF);
    check("illegal_alu",    32'(bus.alu_control), 32'b11111);
    check("illegal_immext", bus.imm_ext,          32'd0);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2 bus.instruction = rand_instr();
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
